lb_write_arb: RTL

Arbiter that merges two local-bus write sources onto the single slave register bus feeding the LLRF register file. These are the host decoder writes and the `fgen` sequencer `lbo_*` writes. Host writes always win. Colliding `fgen` writes are held in a small ordered FIFO and replayed in idle cycles, so triggered sequences are delayed rather than lost. Overflow is flagged and counted for software.

---
 rtl/lb_write_arb.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/lb_write_arb.sv
// Merges host and fgen local-bus writes onto one register bus. Host always wins; colliding fgen writes queue in order.
// Latency: 1 cycle host/bypass; a buffered fgen write leaves 1 cycle after the first host-free cycle in which it is head.
// Backpressure: none upstream (strobes cannot stall); an fgen write that meets a full queue with no pop is dropped and counted.

module lb_write_arb_fifo #(
    parameter int w  = 48,
    parameter int ld = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [w-1:0]  wdat,
    output logic [w-1:0]  rdat,
    output logic [ld:0]   level
);
    logic [w-1:0]  mem [0:(1<<ld)-1];
    logic [ld-1:0] wr_ptr;
    logic [ld-1:0] rd_ptr;

    // Caller never pushes into a full queue without popping, nor pops an empty one.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ld'(1);
            if (pop)  rd_ptr <= rd_ptr + ld'(1);
            if (push && !pop)      level <= level + (ld+1)'(1);
            else if (pop && !push) level <= level - (ld+1)'(1);
        end
    end

    assign rdat = mem[rd_ptr];
endmodule

module lb_write_arb #(
    parameter int aw = 16,
    parameter int dw = 32,
    parameter int ld = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [dw-1:0] h_data,
    input  logic [aw-1:0] h_addr,
    input  logic          h_write,
    input  logic [dw-1:0] f_data,
    input  logic [aw-1:0] f_addr,
    input  logic          f_write,
    input  logic          clr_ovf,
    output logic [dw-1:0] o_data,
    output logic [aw-1:0] o_addr,
    output logic          o_write,
    output logic          o_src,
    output logic [ld:0]   level,
    output logic          ovf,
    output logic [7:0]    drop_cnt
);
    localparam int depth = 1 << ld;

    logic [aw+dw-1:0] head;
    logic [ld:0]      fifo_level;
    logic             full;
    logic             empty;
    logic             pop;
    logic             push;
    logic             bypass;
    logic             drop;

    always_comb begin
        full   = (fifo_level == (ld+1)'(depth));
        empty  = (fifo_level == '0);
        pop    = !h_write && !empty;
        bypass = !h_write && empty && f_write;
        // A full queue still accepts a push when the head leaves in the same cycle.
        push   = f_write && !bypass && (!full || pop);
        drop   = f_write && h_write && full;
    end

    lb_write_arb_fifo #(
        .w  (aw + dw),
        .ld (ld)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdat  ({f_addr, f_data}),
        .rdat  (head),
        .level (fifo_level)
    );

    assign level = fifo_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_write <= 1'b0;
            o_src   <= 1'b0;
            o_addr  <= '0;
            o_data  <= '0;
        end else begin
            o_write <= h_write || pop || bypass;
            if (h_write) begin
                o_src  <= 1'b0;
                o_addr <= h_addr;
                o_data <= h_data;
            end else if (pop) begin
                o_src  <= 1'b1;
                {o_addr, o_data} <= head;
            end else if (bypass) begin
                o_src  <= 1'b1;
                o_addr <= f_addr;
                o_data <= f_data;
            end else begin
                o_src  <= 1'b0;
                o_addr <= '0;
                o_data <= '0;
            end
        end
    end

    // A drop coinciding with a clear leaves exactly that one drop recorded.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_ovf) begin
            ovf      <= drop;
            drop_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule
